disp_rdreq_sched: RTL and testbench
===================================

// Module: disp_rdreq_sched
// PURPOSE
//  Schedules AXI4 burst reads fetching one frame of 32-bit pixels from VRAM into the display pixel FIFO.
//  Sits between the display FIFO and the AXI master AR channel; starts each frame at the timing generator's frame-start pulse.
//  Issues a read only when the FIFO has room for a whole burst. Handles the VBLANK flag handshake with software.
// PARAMETERS
//  H_PIXELS    640  visible pixels per line
//  V_LINES     480  visible lines per frame
//  BURST_LEN   16   beats per AR burst (power of 2, <=256; 4 B/beat)
//  FIFO_DEPTH  512  pixel FIFO depth in words
//  ADDR_W      32   AXI address width
// PORTS
//  ACLK            in   1       system clock
//  ARESETN         in   1       async active-low reset
//  DISP_ON         in   1       display enable, sampled at frame start
//  DISP_ADDR       in   ADDR_W  frame base address, sampled at frame start
//  FRAME_START     in   1       1-cycle pulse from timing gen, start of vertical blank
//  CLR_VBLANK      in   1       software clear of VBLANK
//  FIFO_WCNT       in   10      words currently stored in pixel FIFO
//  M_AXI_ARADDR    out  ADDR_W  burst address
//  M_AXI_ARLEN     out  8       constant BURST_LEN-1
//  M_AXI_ARVALID   out  1       address valid
//  M_AXI_ARREADY   in   1       address accepted
//  M_AXI_RVALID    in   1       read data valid (monitored)
//  M_AXI_RREADY    in   1       read data ready (monitored)
//  M_AXI_RRESP     in   2       read response (monitored)
//  VBLANK          out  1       sticky frame-start flag
//  FRAME_LATE      out  1       sticky: frame start hit before previous frame fully requested
// BEHAVIOUR
//  Reset: all outputs 0; ARADDR 0; state IDLE; outstanding counter 0; burst counter 0.
//  Single clock ACLK; all state async-cleared by ARESETN low, sync elsewhere.
//  TOTAL_BURSTS = H_PIXELS*V_LINES/BURST_LEN (19200 default); must be integral.
//  FSM states:
//   IDLE: on FRAME_START with DISP_ON=1 -> latch base={DISP_ADDR[ADDR_W-1:6],6'b0} (low log2(BURST_LEN*4) bits forced 0), burst_cnt=0 -> CHK.
//   CHK:  if FIFO_WCNT + outstanding + BURST_LEN <= FIFO_DEPTH -> ADDR, else stay.
//   ADDR: ARVALID=1, ARADDR=base+burst_cnt*BURST_LEN*4. Hold ARVALID/ARADDR stable until ARREADY.
//         On ARVALID&&ARREADY: outstanding+=BURST_LEN, burst_cnt++; if last burst -> IDLE else CHK.
//  outstanding: +BURST_LEN on AR handshake, -1 per RVALID&&RREADY; both same cycle -> net +BURST_LEN-1.
//   Width ceil(log2(FIFO_DEPTH+1)); never exceeds FIFO_DEPTH by construction.
//  Check-to-ARVALID latency 1 cycle; AR back-to-back min 2 cycles (ADDR->CHK->ADDR).
//  FRAME_START in CHK: remaining bursts abandoned, FRAME_LATE<=1, new frame latched (if DISP_ON), state CHK, burst_cnt=0; outstanding kept.
//  FRAME_START in ADDR: current burst completes handshake (AXI rule), then abandon as above; FRAME_LATE<=1.
//  DISP_ON=0 at frame start -> stay/return IDLE after current burst; no further AR.
//  DISP_ADDR changes mid-frame ignored until next FRAME_START.
//  VBLANK: set on FRAME_START regardless of DISP_ON; cleared on CLR_VBLANK; both same cycle -> set wins.
//  FRAME_LATE cleared only by reset.
//  Reset mid-burst: ARVALID drops async to 0, outstanding cleared; system resets AXI slave jointly.
// CONFIGURATION
//  DISP_RDREQ_RRESP_CHK_EN defined: adds output RRESP_ERR (1 bit, reset 0), sticky set on
//   RVALID&&RREADY&&RRESP!=2'b00, cleared with VBLANK by CLR_VBLANK (set wins).
//  Undefined: no RRESP_ERR port, RRESP unused.
// TESTING
//  Reset, DISP_ON=1, DISP_ADDR=32'h1000_0000, FRAME_START -> first ARADDR=32'h1000_0000, ARLEN=15, next 32'h1000_0040.
//  Full frame, always-ready slave, FIFO drained 1 word/cycle -> exactly 19200 AR handshakes, last ARADDR=32'h1012_BFC0.
//  FIFO_WCNT=497, outstanding=0 -> ARVALID held 0; FIFO_WCNT=496 -> ARVALID next cycle.
//  ARREADY low 10 cycles -> ARVALID/ARADDR stable all 10 cycles; burst_cnt increments once.
//  FRAME_START at burst 100 -> FRAME_LATE=1, next ARADDR=new base; FRAME_START with CLR_VBLANK same cycle -> VBLANK=1.
//  With DISP_RDREQ_RRESP_CHK_EN, RRESP=2'b10 on one beat -> RRESP_ERR=1 until CLR_VBLANK.

Source files
------------

// File: rtl/disp_rdreq_sched_if.sv
// -----------------------------------------------------------------------------
// disp_rdreq_sched_if
//   Read-address channel plus monitored read-data handshake between the
//   display read scheduler and the AXI4 master.
//
//   araddr  : burst start address              (scheduler -> AXI)
//   arlen   : beats per burst minus one        (scheduler -> AXI)
//   arvalid : address valid                    (scheduler -> AXI)
//   arready : address accepted                 (AXI -> scheduler)
//   rvalid  : read data valid, monitored only  (AXI -> scheduler)
//   rready  : read data ready, monitored only  (AXI -> scheduler)
//   rresp   : read response, monitored only    (AXI -> scheduler)
//
//   master : view used by the scheduler
//   slave  : view used by the AXI side / environment
// -----------------------------------------------------------------------------
interface disp_rdreq_sched_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic              arvalid;
  logic              arready;
  logic              rvalid;
  logic              rready;
  logic [1:0]        rresp;

  modport master (
    output araddr, arlen, arvalid,
    input  arready, rvalid, rready, rresp
  );

  modport slave (
    input  araddr, arlen, arvalid,
    output arready, rvalid, rready, rresp
  );
endinterface

// File: rtl/disp_rdreq_sched.sv
// -----------------------------------------------------------------------------
// disp_rdreq_sched
//   Schedules AXI4 burst reads that fetch one frame of 32-bit pixels from VRAM
//   into the display pixel FIFO. A frame starts on the timing generator's
//   FRAME_START pulse; a burst is only requested when the FIFO has room for
//   every word already in flight plus the whole new burst.
//
// Ports
//   ACLK, ARESETN  : clock, asynchronous active-low reset
//   DISP_ON        : display enable, sampled at frame start
//   DISP_ADDR      : frame base address, sampled at frame start
//   FRAME_START    : 1-cycle pulse at start of vertical blank
//   CLR_VBLANK     : software clear of VBLANK (and RRESP_ERR)
//   FIFO_WCNT      : words currently held in the pixel FIFO
//   m_axi          : AR channel driver + R handshake monitor (master modport)
//   VBLANK         : sticky frame-start flag
//   FRAME_LATE     : sticky, frame start arrived before the previous frame
//                    was fully requested; cleared only by reset
//   RRESP_ERR      : only with DISP_RDREQ_RRESP_CHK_EN defined; sticky flag
//                    for any accepted read beat with a non-OKAY response
//
// Configuration
//   DISP_RDREQ_RRESP_CHK_EN : adds the RRESP_ERR output and its checker.
// -----------------------------------------------------------------------------
module disp_rdreq_sched #(
  parameter int H_PIXELS   = 640,
  parameter int V_LINES    = 480,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 512,
  parameter int ADDR_W     = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic                      DISP_ON,
  input  logic [ADDR_W-1:0]         DISP_ADDR,
  input  logic                      FRAME_START,
  input  logic                      CLR_VBLANK,
  input  logic [9:0]                FIFO_WCNT,
  disp_rdreq_sched_if.master        m_axi,
  output logic                      VBLANK,
  output logic                      FRAME_LATE
`ifdef DISP_RDREQ_RRESP_CHK_EN
  ,
  output logic                      RRESP_ERR
`endif
);

  localparam int TOTAL_BURSTS = (H_PIXELS * V_LINES) / BURST_LEN;
  localparam int BCNT_W       = $clog2(TOTAL_BURSTS + 1);
  localparam int OUT_W        = $clog2(FIFO_DEPTH + 1);
  localparam int ALIGN_W      = $clog2(BURST_LEN * 4);
  localparam int SUM_W        = ((OUT_W > 10) ? OUT_W : 10) + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CHK  = 2'd1,
    ADDR = 2'd2
  } state_t;

  state_t                   state, state_nx;
  logic [ADDR_W-ALIGN_W-1:0] base_hi, pend_hi, new_hi;
  logic [BCNT_W-1:0]        burst_cnt;
  logic [OUT_W-1:0]         outstanding;
  logic                     pend_fs, pend_on, new_on;
  logic                     ar_hs, r_hs, room, last_burst;
  logic                     frame_load, burst_inc, late_set;
  logic [SUM_W-1:0]         need;

  assign ar_hs      = (state == ADDR) && m_axi.arready;
  assign r_hs       = m_axi.rvalid && m_axi.rready;
  // Words already in the FIFO plus words requested but not yet returned plus
  // the new burst must all fit, so the FIFO can never overflow.
  assign need       = SUM_W'(FIFO_WCNT) + SUM_W'(outstanding) + SUM_W'(BURST_LEN);
  assign room       = need <= SUM_W'(FIFO_DEPTH);
  assign last_burst = burst_cnt == BCNT_W'(TOTAL_BURSTS - 1);

  // Address is a pure function of registered state, so it stays stable for
  // as long as ARVALID waits for ARREADY.
  assign m_axi.arvalid = state == ADDR;
  assign m_axi.arlen   = 8'(BURST_LEN - 1);
  assign m_axi.araddr  = {base_hi, {ALIGN_W{1'b0}}} + (ADDR_W'(burst_cnt) << ALIGN_W);

  // NOTE: every combinational output gets a default before the case so no
  // path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_nx   = state;
    frame_load = 1'b0;
    burst_inc  = 1'b0;
    late_set   = 1'b0;
    new_hi     = DISP_ADDR[ADDR_W-1:ALIGN_W];
    new_on     = DISP_ON;
    case (state)
      IDLE: begin
        if (FRAME_START && DISP_ON) begin
          frame_load = 1'b1;
          state_nx   = CHK;
        end
      end
      CHK: begin
        if (FRAME_START) begin
          frame_load = 1'b1;
          late_set   = 1'b1;
          state_nx   = DISP_ON ? CHK : IDLE;
        end else if (room) begin
          state_nx = ADDR;
        end
      end
      ADDR: begin
        if (FRAME_START) late_set = 1'b1;
        if (ar_hs) begin
          burst_inc = 1'b1;
          // A frame start seen while waiting (or right now) restarts the
          // frame only once the pending burst has been accepted.
          if (FRAME_START || pend_fs) begin
            if (!FRAME_START) begin
              new_hi = pend_hi;
              new_on = pend_on;
            end
            frame_load = 1'b1;
            state_nx   = new_on ? CHK : IDLE;
          end else if (last_burst) begin
            state_nx = IDLE;
          end else begin
            state_nx = CHK;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state       <= IDLE;
      base_hi     <= '0;
      burst_cnt   <= '0;
      outstanding <= '0;
      pend_fs     <= 1'b0;
      pend_on     <= 1'b0;
      pend_hi     <= '0;
      VBLANK      <= 1'b0;
      FRAME_LATE  <= 1'b0;
    end else begin
      state <= state_nx;

      if (frame_load) begin
        base_hi   <= new_hi;
        burst_cnt <= '0;
      end else if (burst_inc) begin
        burst_cnt <= burst_cnt + BCNT_W'(1);
      end

      case ({ar_hs, r_hs})
        2'b10:   outstanding <= outstanding + OUT_W'(BURST_LEN);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        2'b11:   outstanding <= outstanding + OUT_W'(BURST_LEN - 1);
        default: outstanding <= outstanding;
      endcase

      if (ar_hs) begin
        pend_fs <= 1'b0;
      end else if (state == ADDR && FRAME_START) begin
        pend_fs <= 1'b1;
        pend_on <= DISP_ON;
        pend_hi <= DISP_ADDR[ADDR_W-1:ALIGN_W];
      end

      if (FRAME_START)     VBLANK <= 1'b1;
      else if (CLR_VBLANK) VBLANK <= 1'b0;

      if (late_set) FRAME_LATE <= 1'b1;
    end
  end

  // Low address bits are forced to burst alignment and never used.
  logic unused_addr_lo;
  assign unused_addr_lo = ^DISP_ADDR[ALIGN_W-1:0];

`ifdef DISP_RDREQ_RRESP_CHK_EN
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)                             RRESP_ERR <= 1'b0;
    else if (r_hs && m_axi.rresp != 2'b00)    RRESP_ERR <= 1'b1;
    else if (CLR_VBLANK)                      RRESP_ERR <= 1'b0;
  end
`else
  logic unused_rresp;
  assign unused_rresp = ^m_axi.rresp;
`endif

endmodule

// File: tb/tb_disp_rdreq_sched.sv
// -----------------------------------------------------------------------------
// tb_disp_rdreq_sched
//   Directed bench for disp_rdreq_sched. The frame is shortened to 48 lines
//   (1920 bursts) so a full frame fits a short run; burst size, FIFO depth and
//   address arithmetic are the default ones.
// -----------------------------------------------------------------------------
module tb_disp_rdreq_sched;

  localparam int TB_BURSTS = 640 * 48 / 16;

  logic        ACLK;
  logic        ARESETN;
  logic        DISP_ON;
  logic [31:0] DISP_ADDR;
  logic        FRAME_START;
  logic        CLR_VBLANK;
  logic [9:0]  FIFO_WCNT;
  logic        VBLANK;
  logic        FRAME_LATE;
`ifdef DISP_RDREQ_RRESP_CHK_EN
  logic        RRESP_ERR;
`endif

  disp_rdreq_sched_if #(.ADDR_W(32)) m_axi ();

  disp_rdreq_sched #(
    .H_PIXELS(640), .V_LINES(48), .BURST_LEN(16), .FIFO_DEPTH(512), .ADDR_W(32)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .DISP_ON(DISP_ON), .DISP_ADDR(DISP_ADDR),
    .FRAME_START(FRAME_START), .CLR_VBLANK(CLR_VBLANK), .FIFO_WCNT(FIFO_WCNT),
    .m_axi(m_axi), .VBLANK(VBLANK), .FRAME_LATE(FRAME_LATE)
`ifdef DISP_RDREQ_RRESP_CHK_EN
    , .RRESP_ERR(RRESP_ERR)
`endif
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  int          n_checks = 0;
  int          n_fail   = 0;
  // Slave / FIFO model state
  int          pending;    // beats requested but not yet returned
  int          fifo_cnt;   // words in modelled FIFO
  int          hs_count;   // AR handshakes seen
  logic [31:0] last_addr;  // address of the latest AR handshake
  logic [1:0]  next_resp;  // response for the next returned beat

  // One cycle of the environment, called just after a falling edge: decides
  // what the slave and FIFO present at the coming rising edge.
  task automatic model_step(input logic rdy);
    logic beat;
    m_axi.arready = rdy;
    beat          = (pending != 0);
    m_axi.rvalid  = beat;
    m_axi.rready  = 1'b1;
    m_axi.rresp   = beat ? next_resp : 2'b00;
    if (beat) begin
      pending   = pending - 1;
      next_resp = 2'b00;
    end
    FIFO_WCNT = 10'(fifo_cnt);
    if (m_axi.arvalid && rdy) begin
      hs_count  = hs_count + 1;
      last_addr = m_axi.araddr;
      pending   = pending + 16;
    end
    fifo_cnt = fifo_cnt + (beat ? 1 : 0) - ((fifo_cnt > 0) ? 1 : 0);
  endtask

  task automatic apply_reset();
    ARESETN = 1'b0;
    DISP_ON = 1'b0; DISP_ADDR = '0; FRAME_START = 1'b0; CLR_VBLANK = 1'b0;
    FIFO_WCNT = '0;
    m_axi.arready = 1'b0; m_axi.rvalid = 1'b0; m_axi.rready = 1'b0; m_axi.rresp = 2'b00;
    pending = 0; fifo_cnt = 0; hs_count = 0; last_addr = '0; next_resp = 2'b00;
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge ACLK);
    n_checks++;
    if (m_axi.arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid: got %b expected 0", m_axi.arvalid); end
    n_checks++;
    if (m_axi.araddr !== 32'h0) begin n_fail++; $display("FAIL reset_araddr: got %h expected 00000000", m_axi.araddr); end
    n_checks++;
    if (VBLANK !== 1'b0) begin n_fail++; $display("FAIL reset_vblank: got %b expected 0", VBLANK); end
    n_checks++;
    if (FRAME_LATE !== 1'b0) begin n_fail++; $display("FAIL reset_frame_late: got %b expected 0", FRAME_LATE); end
    n_checks++;
    if (m_axi.arlen !== 8'd15) begin n_fail++; $display("FAIL arlen: got %0d expected 15", m_axi.arlen); end
`ifdef DISP_RDREQ_RRESP_CHK_EN
    n_checks++;
    if (RRESP_ERR !== 1'b0) begin n_fail++; $display("FAIL reset_rresp_err: got %b expected 0", RRESP_ERR); end
`endif
  endtask

  task automatic test_first_bursts();
    apply_reset();
    @(negedge ACLK);
    FRAME_START = 1'b1; DISP_ON = 1'b1; DISP_ADDR = 32'h1000_0000; m_axi.arready = 1'b1;
    @(negedge ACLK);
    FRAME_START = 1'b0;
    n_checks++;
    if (VBLANK !== 1'b1) begin n_fail++; $display("FAIL first_vblank: got %b expected 1", VBLANK); end
    n_checks++;
    if (m_axi.arvalid !== 1'b0) begin n_fail++; $display("FAIL first_chk_arvalid: got %b expected 0", m_axi.arvalid); end
    @(negedge ACLK);
    n_checks++;
    if ({m_axi.arvalid, m_axi.araddr, m_axi.arlen} !== {1'b1, 32'h1000_0000, 8'd15}) begin
      n_fail++; $display("FAIL first_ar: got v=%b a=%h l=%0d expected v=1 a=10000000 l=15",
                         m_axi.arvalid, m_axi.araddr, m_axi.arlen);
    end
    @(negedge ACLK);
    n_checks++;
    if (m_axi.arvalid !== 1'b0) begin n_fail++; $display("FAIL first_gap_arvalid: got %b expected 0", m_axi.arvalid); end
    @(negedge ACLK);
    m_axi.arready = 1'b0;
    n_checks++;
    if ({m_axi.arvalid, m_axi.araddr} !== {1'b1, 32'h1000_0040}) begin
      n_fail++; $display("FAIL second_ar: got v=%b a=%h expected v=1 a=10000040", m_axi.arvalid, m_axi.araddr);
    end
  endtask

  task automatic test_fifo_threshold();
    apply_reset();
    FIFO_WCNT = 10'd497;
    @(negedge ACLK);
    FRAME_START = 1'b1; DISP_ON = 1'b1; DISP_ADDR = 32'h4000_0000;
    @(negedge ACLK);
    FRAME_START = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge ACLK);
      n_checks++;
      if (m_axi.arvalid !== 1'b0) begin n_fail++; $display("FAIL wcnt497_hold cycle %0d: got %b expected 0", i, m_axi.arvalid); end
    end
    FIFO_WCNT = 10'd496;
    @(negedge ACLK);
    n_checks++;
    if ({m_axi.arvalid, m_axi.araddr} !== {1'b1, 32'h4000_0000}) begin
      n_fail++; $display("FAIL wcnt496_issue: got v=%b a=%h expected v=1 a=40000000", m_axi.arvalid, m_axi.araddr);
    end
  endtask

  // Continues from test_fifo_threshold with ARVALID high at 4000_0000.
  task automatic test_arready_stall();
    DISP_ADDR = 32'h5000_0000;
    for (int i = 0; i < 10; i++) begin
      m_axi.arready = 1'b0;
      @(negedge ACLK);
      n_checks++;
      if ({m_axi.arvalid, m_axi.araddr} !== {1'b1, 32'h4000_0000}) begin
        n_fail++; $display("FAIL stall_stable cycle %0d: got v=%b a=%h expected v=1 a=40000000", i, m_axi.arvalid, m_axi.araddr);
      end
    end
    m_axi.arready = 1'b1;
    @(negedge ACLK);
    m_axi.arready = 1'b0;
    FIFO_WCNT = 10'd0;
    n_checks++;
    if (m_axi.arvalid !== 1'b0) begin n_fail++; $display("FAIL stall_after_hs: got %b expected 0", m_axi.arvalid); end
    @(negedge ACLK);
    n_checks++;
    if ({m_axi.arvalid, m_axi.araddr} !== {1'b1, 32'h4000_0040}) begin
      n_fail++; $display("FAIL stall_next_addr: got v=%b a=%h expected v=1 a=40000040", m_axi.arvalid, m_axi.araddr);
    end
  endtask

  task automatic test_frame_late();
    apply_reset();
    @(negedge ACLK);
    FRAME_START = 1'b1; DISP_ON = 1'b1; DISP_ADDR = 32'h1000_0000; model_step(1'b1);
    @(negedge ACLK);
    FRAME_START = 1'b0; CLR_VBLANK = 1'b1; model_step(1'b1);
    @(negedge ACLK);
    CLR_VBLANK = 1'b0; model_step(1'b1);
    n_checks++;
    if (VBLANK !== 1'b0) begin n_fail++; $display("FAIL vblank_clear: got %b expected 0", VBLANK); end
    for (int i = 0; i < 5000 && hs_count < 100; i++) begin
      @(negedge ACLK);
      model_step(1'b1);
    end
    n_checks++;
    if (hs_count !== 100) begin n_fail++; $display("FAIL reach_burst_100: got %0d expected 100", hs_count); end
    @(negedge ACLK);
    n_checks++;
    if (FRAME_LATE !== 1'b0) begin n_fail++; $display("FAIL late_before: got %b expected 0", FRAME_LATE); end
    FRAME_START = 1'b1; CLR_VBLANK = 1'b1; DISP_ADDR = 32'h2000_0013; model_step(1'b1);
    @(negedge ACLK);
    FRAME_START = 1'b0; CLR_VBLANK = 1'b0; model_step(1'b1);
    n_checks++;
    if (FRAME_LATE !== 1'b1) begin n_fail++; $display("FAIL frame_late_set: got %b expected 1", FRAME_LATE); end
    n_checks++;
    if (VBLANK !== 1'b1) begin n_fail++; $display("FAIL vblank_set_wins: got %b expected 1", VBLANK); end
    for (int i = 0; i < 200 && hs_count < 101; i++) begin
      @(negedge ACLK);
      model_step(1'b1);
    end
    n_checks++;
    if (last_addr !== 32'h2000_0000) begin n_fail++; $display("FAIL new_frame_addr: got %h expected 20000000", last_addr); end
  endtask

  // Continues from test_frame_late: next burst would be 2000_0040.
  task automatic test_frame_start_in_addr();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge ACLK);
      if (m_axi.arvalid) found = 1'b1;
      else model_step(1'b1);
    end
    FRAME_START = 1'b1; DISP_ADDR = 32'h3000_0000; model_step(1'b0);
    n_checks++;
    if ({found, m_axi.araddr} !== {1'b1, 32'h2000_0040}) begin
      n_fail++; $display("FAIL addr_wait: got found=%b a=%h expected found=1 a=20000040", found, m_axi.araddr);
    end
    @(negedge ACLK);
    FRAME_START = 1'b0;
    n_checks++;
    if ({m_axi.arvalid, m_axi.araddr} !== {1'b1, 32'h2000_0040}) begin
      n_fail++; $display("FAIL addr_held_after_fs: got v=%b a=%h expected v=1 a=20000040", m_axi.arvalid, m_axi.araddr);
    end
    model_step(1'b1);
    for (int i = 0; i < 200 && hs_count < 103; i++) begin
      @(negedge ACLK);
      model_step(1'b1);
    end
    n_checks++;
    if ({hs_count, last_addr} !== {32'd103, 32'h3000_0000}) begin
      n_fail++; $display("FAIL fs_in_addr_restart: got n=%0d a=%h expected n=103 a=30000000", hs_count, last_addr);
    end
  endtask

  // Continues from test_frame_start_in_addr: DUT is in the check state.
  task automatic test_disp_off();
    @(negedge ACLK);
    FRAME_START = 1'b1; DISP_ON = 1'b0; model_step(1'b1);
    @(negedge ACLK);
    FRAME_START = 1'b0; model_step(1'b1);
    for (int i = 0; i < 60; i++) begin
      @(negedge ACLK);
      model_step(1'b1);
    end
    n_checks++;
    if ({hs_count, 31'd0, m_axi.arvalid} !== {32'd103, 32'd0}) begin
      n_fail++; $display("FAIL disp_off_no_ar: got n=%0d v=%b expected n=103 v=0", hs_count, m_axi.arvalid);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    @(negedge ACLK);
    FRAME_START = 1'b1; DISP_ON = 1'b1; DISP_ADDR = 32'h1000_0000;
    @(negedge ACLK);
    FRAME_START = 1'b0;
    @(negedge ACLK);
    n_checks++;
    if (m_axi.arvalid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_arvalid: got %b expected 1", m_axi.arvalid); end
    #2 ARESETN = 1'b0;
    #1;
    n_checks++;
    if ({m_axi.arvalid, m_axi.araddr, VBLANK} !== {1'b1 ^ 1'b1, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL async_reset: got v=%b a=%h vb=%b expected v=0 a=00000000 vb=0",
                         m_axi.arvalid, m_axi.araddr, VBLANK);
    end
    @(negedge ACLK);
    ARESETN = 1'b1;
  endtask

  task automatic test_full_frame();
    int          seq_err;
    int          prev;
    logic [31:0] exp_addr;
    seq_err = 0;
    apply_reset();
    @(negedge ACLK);
    FRAME_START = 1'b1; DISP_ON = 1'b1; DISP_ADDR = 32'h1000_0000; model_step(1'b1);
    @(negedge ACLK);
    FRAME_START = 1'b0; model_step(1'b1);
    for (int i = 0; i < 40000 && !(hs_count >= TB_BURSTS && pending == 0); i++) begin
      @(negedge ACLK);
      prev = hs_count;
      model_step(1'b1);
      if (hs_count != prev) begin
        exp_addr = 32'h1000_0000 + 32'((hs_count - 1) * 64);
        if (last_addr !== exp_addr) seq_err++;
      end
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge ACLK);
      model_step(1'b1);
    end
    n_checks++;
    if (hs_count !== TB_BURSTS) begin n_fail++; $display("FAIL frame_burst_count: got %0d expected %0d", hs_count, TB_BURSTS); end
    n_checks++;
    if (last_addr !== 32'h1001_DFC0) begin n_fail++; $display("FAIL frame_last_addr: got %h expected 1001dfc0", last_addr); end
    n_checks++;
    if (seq_err !== 0) begin n_fail++; $display("FAIL frame_addr_sequence: got %0d bad addresses expected 0", seq_err); end
    n_checks++;
    if ({FRAME_LATE, m_axi.arvalid} !== 2'b00) begin
      n_fail++; $display("FAIL frame_end_state: got late=%b v=%b expected late=0 v=0", FRAME_LATE, m_axi.arvalid);
    end
  endtask

`ifdef DISP_RDREQ_RRESP_CHK_EN
  task automatic test_rresp_err();
    apply_reset();
    @(negedge ACLK);
    FRAME_START = 1'b1; DISP_ON = 1'b1; DISP_ADDR = 32'h1000_0000; model_step(1'b1);
    @(negedge ACLK);
    FRAME_START = 1'b0; model_step(1'b1);
    next_resp = 2'b10;
    for (int i = 0; i < 40; i++) begin
      @(negedge ACLK);
      model_step(1'b1);
    end
    n_checks++;
    if (RRESP_ERR !== 1'b1) begin n_fail++; $display("FAIL rresp_err_set: got %b expected 1", RRESP_ERR); end
    @(negedge ACLK);
    CLR_VBLANK = 1'b1; model_step(1'b1);
    @(negedge ACLK);
    CLR_VBLANK = 1'b0; model_step(1'b1);
    n_checks++;
    if (RRESP_ERR !== 1'b0) begin n_fail++; $display("FAIL rresp_err_clear: got %b expected 0", RRESP_ERR); end
  endtask
`endif

  initial begin
    test_reset();
    test_first_bursts();
    test_fifo_threshold();
    test_arready_stall();
    test_frame_late();
    test_frame_start_in_addr();
    test_disp_off();
    test_async_reset();
    test_full_frame();
`ifdef DISP_RDREQ_RRESP_CHK_EN
    test_rresp_err();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
